regfile_write_scheduler: RTL and testbench
==========================================

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 Parameter: RESET_PRIO_A, default 1, round-robin pointer after reset (1 = requester A wins the first conflict, 0 = B wins).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a_valid  input  1  requester A (ALU write-back) holds a write request.
REQ-005 Port: a_addr  input  3  requester A destination register index.
REQ-006 Port: a_data  input  8  requester A write data.
REQ-007 Port: a_ready  output  1  A's request accepted this cycle (combinational grant).
REQ-008 Ports: b_valid / b_addr / b_data / b_ready, with the same widths and meaning as A, for requester B (load unit).
REQ-009 Port: rf_write_enable  output  8  one-hot-or-zero write strobes to the 8-entry register array.
REQ-010 Port: rf_data_in  output  8  shared write data to all register entries.
REQ-011 Port: drop_r0  output  1  pulse: the write committed this cycle targeted index 0 and was discarded.

Function
REQ-012 Handshake: a transfer occurs on a rising edge where valid && ready; a requester SHALL hold addr/data stable while valid && !ready.
REQ-013 Accept at most one request per cycle; ready is a function of valid inputs and the priority pointer only, and never depends on ready.
REQ-014 Only A valid -> a_ready=1; only B valid -> b_ready=1; neither valid -> both 0.
REQ-015 Both valid -> grant the requester the pointer favours; on each conflict grant, move the pointer to favour the loser.
REQ-016 A non-conflict grant SHALL NOT move the pointer.
REQ-017 Output stage is registered: a request accepted at edge N drives rf_write_enable/rf_data_in during cycle N..N+1, and the register captures at edge N+1 (1-cycle latency).
REQ-018 rf_write_enable = 1<<addr for addr 1..7; all zero when no transfer occurred at the previous edge.
REQ-019 addr 0 writes: accepted (ready asserted normally), rf_write_enable stays 8'h00, drop_r0=1 for that one cycle, rf_data_in still loaded.
REQ-020 rf_data_in holds its last value when no transfer occurs.
REQ-021 Back-to-back writes to the same index are legal; each produces its own one-cycle strobe; last write wins.
REQ-022 At most one bit of rf_write_enable is ever set.

Reset
REQ-023 While rst=1: a_ready=0, b_ready=0, rf_write_enable=8'h00, rf_data_in=8'h00, drop_r0=0, pointer=RESET_PRIO_A.
REQ-024 Reset asserted mid-operation SHALL discard an accepted-but-uncommitted write (the strobe is cleared immediately, asynchronously).
REQ-025 First grant is possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro RF_WR_COUNT_EN: when defined, add output wr_count [7:0], incremented by 1 on each committed nonzero-index write, wrapping 8'hFF->8'h00, reset 8'h00; index-0 drops are not counted.
REQ-027 When RF_WR_COUNT_EN is undefined, the wr_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset release, a_valid=1, a_addr=3, a_data=8'h5A for one cycle -> next cycle rf_write_enable=8'h08, rf_data_in=8'h5A, then 8'h00.
REQ-029 RESET_PRIO_A=1, A and B both valid for 4 cycles (addrs 1/2) -> grants A,B,A,B; strobes 8'h02,8'h04,8'h02,8'h04.
REQ-030 b_valid=1, b_addr=0, b_data=8'hFF -> b_ready=1, next cycle rf_write_enable=8'h00, drop_r0=1, wr_count unchanged.
REQ-031 Accept A (addr 7), assert rst before the next edge -> rf_write_enable=8'h00 immediately, register 7 unwritten.
REQ-032 RF_WR_COUNT_EN defined, 257 committed writes to addr 5 -> wr_count=8'h01.
REQ-033 Only B valid for 3 cycles, then A and B conflict -> pointer unchanged by B-only grants, first conflict goes to A (RESET_PRIO_A=1).

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Two-requester register-file write scheduler: round-robin arbitration with a
// registered one-cycle write stage. Optional write counter under RF_WR_COUNT_EN.
module regfile_write_scheduler #(
  parameter bit RESET_PRIO_A = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] rf_write_enable,
  output logic [7:0] rf_data_in,
`ifdef RF_WR_COUNT_EN
  output logic [7:0] wr_count,
`endif
  output logic       drop_r0
);

  logic       ptr_a_q, ptr_a_d;
  logic [7:0] we_q, we_d;
  logic [7:0] data_q, data_d;
  logic       drop_q, drop_d;
  logic       a_grant, b_grant;
  logic [2:0] sel_addr;

  // ptr_a_q set means A wins the next conflict; only conflicts move it.
  always_comb begin
    a_grant = !rst && a_valid && (!b_valid || ptr_a_q);
    b_grant = !rst && b_valid && (!a_valid || !ptr_a_q);
  end

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ptr_a_d  = ptr_a_q;
    we_d     = '0;
    drop_d   = 1'b0;
    data_d   = data_q;
    sel_addr = a_grant ? a_addr : b_addr;
    if (a_valid && b_valid) ptr_a_d = ~ptr_a_q;
    if (a_grant || b_grant) begin
      data_d = a_grant ? a_data : b_data;
      if (sel_addr == 3'd0) drop_d = 1'b1;
      else                  we_d   = 8'b1 << sel_addr;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge; async reset clears a pending strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_a_q <= RESET_PRIO_A;
      we_q    <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      ptr_a_q <= ptr_a_d;
      we_q    <= we_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_data_in      = data_q;
  assign drop_r0         = drop_q;

`ifdef RF_WR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counts at the commit edge, so writes discarded by reset never count.
  always_comb begin
    cnt_d = cnt_q;
    if (|we_q) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign wr_count = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler (default parameters).
module tb_regfile_write_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, drop_r0;
  logic [7:0] rf_write_enable, rf_data_in;
`ifdef RF_WR_COUNT_EN
  logic [7:0] wr_count;
  logic [7:0] cnt_snap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_scheduler #(.RESET_PRIO_A(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_write_enable(rf_write_enable), .rf_data_in(rf_data_in),
`ifdef RF_WR_COUNT_EN
    .wr_count(wr_count),
`endif
    .drop_r0(drop_r0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
  endtask

  initial begin
    // Reset state, with requests pending to show ready is suppressed.
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    #10;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_we", rf_write_enable, 8'h00);
    check("rst_data", rf_data_in, 8'h00);
    check("rst_drop", drop_r0, 0);
`ifdef RF_WR_COUNT_EN
    check("rst_count", wr_count, 8'h00);
`endif
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    rst = 1'b0;

    // Single A write to index 3.
    drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    check("a_only_a_ready", a_ready, 1);
    check("a_only_b_ready", b_ready, 0);
    step();
    check("a_only_we", rf_write_enable, 8'h08);
    check("a_only_data", rf_data_in, 8'h5A);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    check("idle_readies", {a_ready, b_ready}, 2'b00);
    step();
    check("idle_we", rf_write_enable, 8'h00);
    check("idle_data_hold", rf_data_in, 8'h5A);

    // Sustained conflict: A,B,A,B.
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr%0d_ready", i), {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      check($sformatf("rr%0d_we", i), rf_write_enable, (i % 2 == 0) ? 8'h02 : 8'h04);
      check($sformatf("rr%0d_data", i), rf_data_in, (i % 2 == 0) ? 8'h11 : 8'h22);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    check("rr_end_we", rf_write_enable, 8'h00);

    // Index-0 write from B is accepted but dropped.
`ifdef RF_WR_COUNT_EN
    cnt_snap = wr_count;
`endif
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF);
    check("r0_b_ready", b_ready, 1);
    check("r0_a_ready", a_ready, 0);
    step();
    check("r0_we", rf_write_enable, 8'h00);
    check("r0_drop", drop_r0, 1);
    check("r0_data", rf_data_in, 8'hFF);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    check("r0_drop_clear", drop_r0, 0);
    check("r0_data_hold", rf_data_in, 8'hFF);
`ifdef RF_WR_COUNT_EN
    check("r0_count", wr_count, cnt_snap);
`endif

    // B-only grants leave the pointer alone; the next conflict goes to A.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h33);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bonly%0d_ready", i), {a_ready, b_ready}, 2'b01);
      step();
      check($sformatf("bonly%0d_we", i), rf_write_enable, 8'h10);
    end
    drive(1'b1, 3'd6, 8'h44, 1'b1, 3'd4, 8'h33);
    check("ptr_hold_ready", {a_ready, b_ready}, 2'b10);
    step();
    check("ptr_hold_we", rf_write_enable, 8'h40);
    check("ptr_hold_data", rf_data_in, 8'h44);

    // Pointer now favours B. Accept A to index 7, then reset before commit.
    drive(1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 8'h00);
    check("pre_rst_a_ready", a_ready, 1);
    step();
    check("pre_rst_we", rf_write_enable, 8'h80);
    rst = 1'b1;
    #1;
    check("midrst_we", rf_write_enable, 8'h00);
    check("midrst_data", rf_data_in, 8'h00);
    check("midrst_a_ready", a_ready, 0);
    drive(1'b1, 3'd5, 8'h55, 1'b1, 3'd2, 8'h66);
    step();
    check("midrst_we_held", rf_write_enable, 8'h00);
    rst = 1'b0;
    #1;
    // Pointer back to reset value: A wins; grant on the first edge after release.
    check("post_rst_ready", {a_ready, b_ready}, 2'b10);
    drive(1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 8'h00);
`ifdef RF_WR_COUNT_EN
    check("post_rst_count", wr_count, 8'h00);
    for (int i = 0; i < 257; i++) step();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    step();
    check("count_wrap", wr_count, 8'h01);
`else
    step();
    check("post_rst_we", rf_write_enable, 8'h20);
    check("post_rst_data", rf_data_in, 8'h55);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    check("post_rst_idle", rf_write_enable, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
